// File: rtl/vmm_if.sv
// vmm_if: operand write port, run control and result handshake for vmm_engine.
// The master side is the operand source / result consumer, the slave side is the engine.
interface vmm_if #(
   parameter int DW = 4,
   parameter int N  = 5,
   parameter int M  = 5,
   parameter int OW = 8
);
   localparam int MX = N > M ? N : M;
   localparam int AW = MX > 1 ? $clog2(MX) : 1;
   logic          wr_en;
   logic          wr_mat;
   logic [AW-1:0] wr_row;
   logic [AW-1:0] wr_col;
   logic [DW-1:0] wr_data;
   logic          start_i;
   logic          done_i;
   logic          next_o;
   logic          busy_o;
   logic [2:0]    state_o;
   logic [OW-1:0] vmm_out;
   logic [AW-1:0] i;
   logic [AW-1:0] j;
   logic          ovf_o;
   modport master (
      output wr_en, wr_mat, wr_row, wr_col, wr_data, start_i, done_i,
      input  next_o, busy_o, state_o, vmm_out, i, j, ovf_o
   );
   modport slave (
      input  wr_en, wr_mat, wr_row, wr_col, wr_data, start_i, done_i,
      output next_o, busy_o, state_o, vmm_out, i, j, ovf_o
   );
endinterface

// File: rtl/vmm_engine.sv
// vmm_engine: y = x*A, one MAC per clock, column results handed out over next_o/done_i.
// Define VMM_SAT_EN to saturate vmm_out on overflow instead of wrapping.
module vmm_engine #(
   parameter int DW = 4,
   parameter int N  = 5,
   parameter int M  = 5,
   parameter int OW = 8
) (
   input logic vmm_clk,
   input logic rst_,
   vmm_if.slave bus
);
   localparam int MX = N > M ? N : M;
   localparam int AW = MX > 1 ? $clog2(MX) : 1;
   localparam int SW = 2 * DW + $clog2(N);
   localparam int XW = SW > OW ? SW : OW;
   typedef enum logic [2:0] {IDLE = 3'd0, MAC = 3'd1, OUT = 3'd2, DONE = 3'd3} state_t;
   state_t        state, state_n;
   logic [DW-1:0] xr [N];
   logic [DW-1:0] ar [N][M];
   logic [SW-1:0] acc, acc_n;
   logic [XW-1:0] sum;
   logic [OW-1:0] res, out;
   logic [AW-1:0] i, j;
   logic          nxt, busy, ovf, ovf_now, wr_ok, go, last_i, last_j, rest;
   always_comb begin
      rest    = state == IDLE || state == DONE;
      wr_ok   = rest && bus.wr_en && 32'(bus.wr_row) < N && (!bus.wr_mat || 32'(bus.wr_col) < M);
      go      = rest && bus.start_i && !bus.wr_en;
      last_i  = 32'(i) == N - 1;
      last_j  = 32'(j) == M - 1;
      acc_n   = acc + SW'(xr[i]) * SW'(ar[i][j]);
      sum     = XW'(acc_n);
      ovf_now = (sum >> OW) != '0;
      state_n = go ? MAC :
                (state == MAC && last_i) ? OUT :
                (state == OUT && bus.done_i) ? (last_j ? DONE : MAC) : state;
   end
`ifdef VMM_SAT_EN
   assign res = ovf_now ? '1 : sum[OW-1:0];
`else
   assign res = sum[OW-1:0];
`endif
   always_ff @(posedge vmm_clk or negedge rst_) begin
      if (!rst_) state <= IDLE;
      else state <= state_n;
   end
   // i stays at N-1 while a result waits in OUT; the ack rewinds it for the next column
   always_ff @(posedge vmm_clk or negedge rst_) begin
      if (!rst_) begin
         for (int r = 0; r < N; r++) begin
            xr[r] <= '0;
            for (int c = 0; c < M; c++) ar[r][c] <= '0;
         end
         acc  <= '0;
         out  <= '0;
         i    <= '0;
         j    <= '0;
         nxt  <= 1'b0;
         busy <= 1'b0;
         ovf  <= 1'b0;
      end else begin
         nxt  <= state_n == OUT;
         busy <= state_n == MAC || state_n == OUT;
         if (wr_ok && bus.wr_mat) ar[bus.wr_row][bus.wr_col] <= bus.wr_data;
         if (wr_ok && !bus.wr_mat) xr[bus.wr_row] <= bus.wr_data;
         if (go) begin
            acc <= '0;
            i   <= '0;
            j   <= '0;
            ovf <= 1'b0;
         end
         if (state == MAC) begin
            acc <= acc_n;
            if (last_i) begin
               out <= res;
               ovf <= ovf | ovf_now;
            end else i <= i + 1'b1;
         end
         if (state == OUT && bus.done_i && !last_j) begin
            acc <= '0;
            i   <= '0;
            j   <= j + 1'b1;
         end
      end
   end
   assign bus.next_o  = nxt;
   assign bus.busy_o  = busy;
   assign bus.state_o = state;
   assign bus.vmm_out = out;
   assign bus.i       = i;
   assign bus.j       = j;
   assign bus.ovf_o   = ovf;
endmodule

// File: tb/tb_vmm_engine.sv
// tb_vmm_engine: table-driven operand/result vectors plus hand-written handshake,
// ignored-input and async-reset sequences for vmm_engine at default parameters.
module tb_vmm_engine;
   localparam int DW = 4, N = 5, M = 5, OW = 8;
`ifdef VMM_SAT_EN
   localparam logic [7:0] BIG = 8'hFF;
   localparam logic [7:0] Y256 = 8'hFF;
`else
   localparam logic [7:0] BIG = 8'h65;
   localparam logic [7:0] Y256 = 8'h00;
`endif
   logic clk = 1'b0;
   logic rst_ = 1'b0;
   int tests = 0, fails = 0;
   vmm_if #(.DW(DW), .N(N), .M(M), .OW(OW)) bus ();
   vmm_engine #(.DW(DW), .N(N), .M(M), .OW(OW)) dut (.vmm_clk(clk), .rst_(rst_), .bus(bus));
   always #5 clk = ~clk;
   typedef struct packed {
      logic [4:0][3:0]      x;
      logic [4:0][4:0][3:0] a;
      logic [4:0][7:0]      y;
      logic                 ovf;
   } vec_t;
   vec_t tbl [7];
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask
   task automatic wr(input logic mat, input int row, input int col, input int data, input logic st);
      bus.wr_en   = 1'b1;
      bus.wr_mat  = mat;
      bus.wr_row  = 3'(row);
      bus.wr_col  = 3'(col);
      bus.wr_data = 4'(data);
      bus.start_i = st;
      tick;
      bus.wr_en   = 1'b0;
      bus.start_i = 1'b0;
   endtask
   task automatic start;
      bus.start_i = 1'b1;
      tick;
      bus.start_i = 1'b0;
   endtask
   task automatic ack;
      bus.done_i = 1'b1;
      tick;
      bus.done_i = 1'b0;
   endtask
   task automatic wait_next(output int n);
      n = 0;
      while (!bus.next_o && n < 50) begin
         tick;
         n++;
      end
   endtask
   // last x write carries start_i, which must be ignored while the write lands
   task automatic load(input int k);
      for (int r = 0; r < N; r++)
         for (int c = 0; c < M; c++) wr(1'b1, r, c, int'(tbl[k].a[r][c]), 1'b0);
      for (int r = 0; r < N - 1; r++) wr(1'b0, r, 0, int'(tbl[k].x[r]), 1'b0);
      wr(1'b0, 6, 0, 15, 1'b0);
      wr(1'b1, 6, 0, 15, 1'b0);
      wr(1'b1, 0, 6, 15, 1'b0);
      wr(1'b0, N - 1, 0, int'(tbl[k].x[N-1]), 1'b1);
      chk($sformatf("v%0d wr+start busy", k), 32'(bus.busy_o), 0);
   endtask
   task automatic run(input int k);
      int n;
      start;
      chk($sformatf("v%0d state MAC", k), 32'(bus.state_o), 1);
      for (int c = 0; c < M; c++) begin
         wait_next(n);
         chk($sformatf("v%0d latency[%0d]", k, c), n, 5);
         chk($sformatf("v%0d y[%0d]", k, c), 32'(bus.vmm_out), 32'(tbl[k].y[c]));
         chk($sformatf("v%0d j[%0d]", k, c), 32'(bus.j), c);
         ack;
      end
      chk($sformatf("v%0d state DONE", k), 32'(bus.state_o), 3);
      chk($sformatf("v%0d next_o DONE", k), 32'(bus.next_o), 0);
      chk($sformatf("v%0d busy DONE", k), 32'(bus.busy_o), 0);
      chk($sformatf("v%0d vmm_out DONE", k), 32'(bus.vmm_out), 32'(tbl[k].y[M-1]));
      chk($sformatf("v%0d ovf", k), 32'(bus.ovf_o), 32'(tbl[k].ovf));
   endtask
   task automatic chk_reset(input string tag);
      chk({tag, " state"}, 32'(bus.state_o), 0);
      chk({tag, " next_o"}, 32'(bus.next_o), 0);
      chk({tag, " busy"}, 32'(bus.busy_o), 0);
      chk({tag, " vmm_out"}, 32'(bus.vmm_out), 0);
      chk({tag, " i"}, 32'(bus.i), 0);
      chk({tag, " j"}, 32'(bus.j), 0);
      chk({tag, " ovf"}, 32'(bus.ovf_o), 0);
   endtask
   initial begin
      #500000;
      $display("FAIL global timeout");
      $fatal(1);
   end
   initial begin
      int n;
      for (int k = 0; k < 7; k++) tbl[k] = '0;
      for (int r = 0; r < N; r++) begin
         tbl[0].x[r] = 4'(r + 1);
         tbl[1].x[r] = 4'd15;
         tbl[2].x[r] = 4'(r + 1);
         for (int c = 0; c < M; c++) begin
            tbl[0].a[r][c] = 4'd1;
            tbl[1].a[r][c] = 4'd15;
            tbl[2].a[r][c] = 4'(c);
         end
      end
      for (int c = 0; c < M; c++) begin
         tbl[0].y[c] = 8'h0F;
         tbl[1].y[c] = BIG;
         tbl[4].a[0][c] = 4'd15;
         tbl[4].a[1][c] = 4'd2;
         tbl[5].a[0][c] = 4'd15;
         tbl[5].a[1][c] = 4'd2;
         tbl[5].a[2][c] = 4'd1;
         tbl[4].y[c] = 8'hFF;
         tbl[5].y[c] = Y256;
      end
      tbl[1].ovf = 1'b1;
      tbl[2].y = {8'h3C, 8'h2D, 8'h1E, 8'h0F, 8'h00};
      tbl[3].x[0] = 4'd9;
      tbl[3].a[0][0] = 4'd1;
      tbl[3].y[0] = 8'h09;
      tbl[4].x = {4'd0, 4'd0, 4'd1, 4'd15, 4'd15};
      tbl[5].x = {4'd0, 4'd0, 4'd1, 4'd15, 4'd15};
      tbl[5].ovf = 1'b1;
      bus.wr_en = 1'b0;
      bus.wr_mat = 1'b0;
      bus.wr_row = '0;
      bus.wr_col = '0;
      bus.wr_data = '0;
      bus.start_i = 1'b0;
      bus.done_i = 1'b0;
      #12;
      chk_reset("reset");
      rst_ = 1'b1;
      tick;
      for (int k = 0; k < 6; k++) begin
         load(k);
         run(k);
      end
      // write during MAC and start during OUT must both be ignored; ack held off 10 cycles
      load(0);
      start;
      tick;
      wr(1'b0, 0, 0, 7, 1'b0);
      wait_next(n);
      chk("hold latency", n, 3);
      chk("hold y[0]", 32'(bus.vmm_out), 32'h0F);
      start;
      for (int t = 0; t < 10; t++) begin
         chk($sformatf("hold next_o t%0d", t), 32'(bus.next_o), 1);
         chk($sformatf("hold vmm_out t%0d", t), 32'(bus.vmm_out), 32'h0F);
         tick;
      end
      chk("hold i", 32'(bus.i), N - 1);
      chk("hold j", 32'(bus.j), 0);
      chk("hold state", 32'(bus.state_o), 2);
      ack;
      chk("ack next_o low", 32'(bus.next_o), 0);
      chk("ack state MAC", 32'(bus.state_o), 1);
      for (int c = 1; c < M; c++) begin
         wait_next(n);
         chk($sformatf("hold latency[%0d]", c), n, 5);
         chk($sformatf("hold y[%0d]", c), 32'(bus.vmm_out), 32'h0F);
         chk($sformatf("hold j[%0d]", c), 32'(bus.j), c);
         ack;
      end
      chk("hold DONE", 32'(bus.state_o), 3);
      run(0);
      // async reset in the middle of a column
      start;
      n = 0;
      while (bus.i != 3'd2 && n < 20) begin
         tick;
         n++;
      end
      chk("reach i=2", 32'(bus.i), 2);
      chk("reach MAC", 32'(bus.state_o), 1);
      rst_ = 1'b0;
      #1;
      chk_reset("midrun reset");
      tick;
      rst_ = 1'b1;
      tick;
      run(6);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/vmm_engine.md
# vmm_engine

Parametrised vector-matrix multiply engine computing y = x·A for an N-element vector x and an N×M matrix A, with element width, dimensions and result width set by parameters. Operands are written into internal registers over a simple write port. The engine runs one multiply-accumulate per clock and presents each column result over a valid/acknowledge handshake (next_o / done_i). Sits between operand sources (switches/keys or a host) and the display/bin2bcd path, replacing the fixed-size VMM.

## Interface
- DW, 4, element width (unsigned)
- N, 5, vector length / matrix rows
- M, 5, matrix columns
- OW, 8, result width on vmm_out
- localparam AW = $clog2(max(N,M)), index width; localparam SW = 2*DW + $clog2(N), full accumulator width

- vmm_clk  in  1  clock; single clock domain
- rst_  in  1  reset, asynchronous, active-low
- wr_en  in  1  operand write strobe
- wr_mat  in  1  1 = write A[wr_row][wr_col], 0 = write x[wr_row]
- wr_row  in  AW  row / vector index
- wr_col  in  AW  column index (ignored for x)
- wr_data  in  DW  operand value
- start_i  in  1  start a full y computation
- done_i  in  1  consumer acknowledge of current result
- next_o  out  1  vmm_out holds a valid column result
- busy_o  out  1  high in MAC or OUT
- state_o  out  3  current state encoding
- vmm_out  out  OW  result y[j]
- i  out  AW  current row index
- j  out  AW  current column index
- ovf_o  out  1  sticky: some y[j] of this run exceeded 2^OW-1

## Operation
- States: IDLE=0, MAC=1, OUT=2, DONE=3 on state_o.
- Reset: state IDLE; all x, A registers, accumulator, vmm_out, i, j = 0; next_o, busy_o, ovf_o = 0.
- Writes accepted only in IDLE or DONE; out-of-range indices (≥N or ≥M) ignored; writes during MAC/OUT ignored.
- IDLE/DONE: start_i high and wr_en low → MAC, i=0, j=0, acc=0, ovf_o cleared. start_i with wr_en in the same cycle: write performed, start ignored.
- MAC: acc += x[i]*A[i][j] at SW bits, unsigned; i increments. After the MAC with i=N-1 → OUT, vmm_out loaded, next_o=1.
- OUT: vmm_out and next_o hold until done_i sampled high. Then j==M-1 → DONE; else j+1, i=0, acc=0 → MAC.
- DONE: next_o=0, busy_o=0, vmm_out holds last result, ovf_o holds.
- done_i outside OUT ignored; start_i in MAC/OUT ignored.
- Result width: sum ≥ 2^OW sets ovf_o; vmm_out per Configuration. If OW ≥ SW, zero-extended, ovf_o never set.

## Timing
- All outputs registered.
- start_i sampled at edge t → MAC at t+1 … t+N; next_o high from t+N+1.
- done_i sampled at edge u in OUT → next_o low and MAC from u+1; next next_o at u+N+1.
- Per column: N MAC cycles + 1 + ack-wait cycles; minimum run M·(N+1) cycles.
- Async reset at any point (including mid-MAC or OUT) forces reset values immediately; no partial result emitted.

## Configuration
- VMM_SAT_EN defined: sum ≥ 2^OW → vmm_out = all ones (2^OW-1).
- VMM_SAT_EN undefined: vmm_out = sum[OW-1:0] (wrap). ovf_o behaves identically in both.

## Test plan
- Defaults; x=[1,2,3,4,5], all A=1; start → five results 0x0F; first next_o 6 cycles after start; j steps 0→4; DONE; ovf_o=0.
- x all 15, A all 15 (sum 1125) → with VMM_SAT_EN vmm_out=0xFF, without 0x65; ovf_o=1 in both.
- Hold done_i low 10 cycles in OUT → next_o, vmm_out, i, j stable; ack → next result 6 cycles later.
- Drop rst_ when i=2 in MAC → state_o=0, next_o=0, vmm_out=0 at once; start without writes → five 0x00 results.
- Write x[0]=7 during MAC and pulse start_i in OUT → both ignored; results match pre-start operands.
- A = identity in column 0, x=[9,0,0,0,0]; wr_row=6 write ignored → y[0]=0x09, other columns 0x00.
